// File: rtl/frame_update_ctrl_if.sv
// frame_update_ctrl_if: physics step handshake and hit bus between the frame controller and the physics engine
// Ports: master (controller) drives o_step_req and samples i_step_ack, i_phys_ball_x/y and i_hit;
// slave (physics) is the mirror image.
interface frame_update_ctrl_if #(
   parameter int XW = 9,
   parameter int YW = 10
);
   logic          o_step_req;
   logic          i_step_ack;
   logic [XW-1:0] i_phys_ball_x;
   logic [YW-1:0] i_phys_ball_y;
   logic          i_hit;
   modport master (output o_step_req, input i_step_ack, i_phys_ball_x, i_phys_ball_y, i_hit);
   modport slave (input o_step_req, output i_step_ack, i_phys_ball_x, i_phys_ball_y, i_hit);
endinterface

// File: rtl/frame_update_ctrl.sv
// frame_update_ctrl: once-per-frame physics step sequencer with tear-free ball coordinates and hit flash
// Ports: i_clk, i_rst (sync, active-high), i_v_coord (VGA line), phys (step req/ack, new ball x/y, hit pulse),
// o_screen_ball_x/y and o_ball_color to the renderer, o_frame_cnt (wrapping), o_missed_cnt (saturating).
// Optional FRAME_UPDATE_PAUSE_EN adds i_pause, which suppresses the step request and freezes the flash.
module frame_update_ctrl #(
   parameter int          SCREEN_WIDTH  = 400,
   parameter int          SCREEN_HEIGHT = 600,
   parameter logic [11:0] BALL_COLOR    = 12'hFFF,
   parameter logic [11:0] FLASH_COLOR   = 12'hF00,
   parameter int          FLASH_FRAMES  = 8,
   localparam int         XW            = $clog2(SCREEN_WIDTH),
   localparam int         YW            = $clog2(SCREEN_HEIGHT)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [9:0]          i_v_coord,
`ifdef FRAME_UPDATE_PAUSE_EN
   input  logic                i_pause,
`endif
   frame_update_ctrl_if.master phys,
   output logic [XW-1:0]       o_screen_ball_x,
   output logic [YW-1:0]       o_screen_ball_y,
   output logic [11:0]         o_ball_color,
   output logic [15:0]         o_frame_cnt,
   output logic [7:0]          o_missed_cnt
);
   typedef enum logic [1:0] {ACTIVE, REQ, DONE} state_t;
   state_t     state, state_nx;
   logic       vblank, vb_q, vb_rise, vb_fall, pause;
   logic       req, req_nx, latch, miss, hit_pend, pend;
   logic [7:0] flash, flash_nx;
`ifdef FRAME_UPDATE_PAUSE_EN
   assign pause = i_pause;
`else
   assign pause = 1'b0;
`endif
   assign vblank         = i_v_coord >= 10'(SCREEN_HEIGHT);
   assign vb_rise        = vblank & ~vb_q;
   assign vb_fall        = ~vblank & vb_q;
   // a hit in the very cycle of vb_rise still counts for that frame
   assign pend           = hit_pend | phys.i_hit;
   assign phys.o_step_req = req;
   always_comb begin
      state_nx = state;
      req_nx   = req;
      latch    = 1'b0;
      miss     = 1'b0;
      case (state)
         ACTIVE: if (vb_rise && !pause) begin
            state_nx = REQ;
            req_nx   = 1'b1;
         end
         // ack beats a simultaneous vb_fall, and then DONE is skipped
         REQ: if (phys.i_step_ack) begin
            latch    = 1'b1;
            req_nx   = 1'b0;
            state_nx = vb_fall ? ACTIVE : DONE;
         end else if (vb_fall) begin
            miss     = 1'b1;
            req_nx   = 1'b0;
            state_nx = ACTIVE;
         end
         DONE: state_nx = vb_fall ? ACTIVE : DONE;
         default: state_nx = ACTIVE;
      endcase
      flash_nx = pend ? 8'(FLASH_FRAMES) : (flash != 8'd0) ? flash - 8'd1 : flash;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= ACTIVE;
         req             <= 1'b0;
         vb_q            <= 1'b0;
         hit_pend        <= 1'b0;
         flash           <= 8'd0;
         o_screen_ball_x <= XW'(SCREEN_WIDTH / 2);
         o_screen_ball_y <= YW'(SCREEN_HEIGHT / 2);
         o_ball_color    <= BALL_COLOR;
         o_frame_cnt     <= 16'd0;
         o_missed_cnt    <= 8'd0;
      end else begin
         state    <= state_nx;
         req      <= req_nx;
         vb_q     <= vblank;
         // pending is consumed only by an unpaused frame start
         hit_pend <= (vb_rise && !pause) ? 1'b0 : pend;
         if (vb_rise) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
            if (!pause) begin
               flash        <= flash_nx;
               o_ball_color <= (flash_nx != 8'd0) ? FLASH_COLOR : BALL_COLOR;
            end
         end
         if (latch) begin
            o_screen_ball_x <= phys.i_phys_ball_x;
            o_screen_ball_y <= phys.i_phys_ball_y;
         end
         if (miss && o_missed_cnt != 8'hFF) o_missed_cnt <= o_missed_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_frame_update_ctrl.sv
// tb_frame_update_ctrl: randomized frame-level scoreboard bench for frame_update_ctrl
module tb_frame_update_ctrl;
`ifdef FRAME_UPDATE_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif
   typedef struct {int fc; int color; int x; int y; int mc; int req;} rise_t;
   typedef struct {int x; int y; int mc;} end_t;
   logic        clk = 1'b0, rst = 1'b1, pause = 1'b0;
   logic [9:0]  v = 10'd0;
   logic [8:0]  sx;
   logic [9:0]  sy;
   logic [11:0] color;
   logic [15:0] fc;
   logic [7:0]  mc;
   int          checks = 0, errors = 0;
   rise_t       rise_q[$];
   end_t        end_q[$];
   int          m_fc, m_x, m_y, m_mc, m_flash;
   bit          m_pend;
   always #5 clk = ~clk;
   frame_update_ctrl_if #(.XW(9), .YW(10)) phys ();
   frame_update_ctrl dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_v_coord(v),
`ifdef FRAME_UPDATE_PAUSE_EN
      .i_pause(pause),
`endif
      .phys(phys),
      .o_screen_ball_x(sx),
      .o_screen_ball_y(sy),
      .o_ball_color(color),
      .o_frame_cnt(fc),
      .o_missed_cnt(mc)
   );
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask
   function automatic void model_reset();
      m_fc = 0; m_x = 200; m_y = 300; m_mc = 0; m_flash = 0; m_pend = 1'b0;
   endfunction
   // frame start: counts, flash rule, and the state the renderer sees at that moment
   function automatic void model_rise(bit hit, bit p);
      rise_t r;
      if (hit) m_pend = 1'b1;
      m_fc = (m_fc + 1) % 65536;
      if (!p) begin
         if (m_pend) begin m_flash = 8; m_pend = 1'b0; end
         else if (m_flash > 0) m_flash--;
      end
      r.fc = m_fc; r.color = (m_flash > 0) ? 'hF00 : 'hFFF;
      r.x = m_x; r.y = m_y; r.mc = m_mc; r.req = p ? 0 : 1;
      rise_q.push_back(r);
   endfunction
   // end of a handshake: either new coords or one more miss
   function automatic void model_end(bit acked, int x, int y);
      end_t e;
      if (acked) begin m_x = x; m_y = y; end
      else if (m_mc < 255) m_mc++;
      e.x = m_x; e.y = m_y; e.mc = m_mc;
      end_q.push_back(e);
   endfunction
   task automatic drive_phys(bit ack, int x, int y);
      phys.i_step_ack    = ack;
      phys.i_phys_ball_x = ack ? 9'(x) : 9'($urandom_range(399, 0));
      phys.i_phys_ball_y = ack ? 10'(y) : 10'($urandom_range(599, 0));
   endtask
   // one frame: act active lines, blank lines of vblank, then one active line on which vb_fall is seen;
   // d = cycle (counted from the vb_rise edge) on which ack is sampled, outside 1..blank means no valid ack
   task automatic frame(int act, int blank, int d, int x, int y, int hit_at, bit p, bit p_late);
      pause = p & PAUSE_EN;
      model_rise(hit_at >= 0, pause);
      if (!pause) model_end(d >= 1 && d <= blank, x, y);
      for (int i = 0; i < act; i++) begin
         @(negedge clk);
         v = 10'($urandom_range(599, 0));
         phys.i_hit = (i == hit_at);
         drive_phys(1'b0, x, y);
      end
      for (int j = 0; j < blank; j++) begin
         @(negedge clk);
         v = 10'(600 + $urandom_range(24, 0));
         phys.i_hit = (j == 0 && hit_at == act);
         drive_phys(j == d, x, y);
         pause = (p | (p_late && j >= 1)) & PAUSE_EN;
      end
      @(negedge clk);
      v = 10'($urandom_range(599, 0));
      phys.i_hit = 1'b0;
      drive_phys(d == blank, x, y);
      pause = p & PAUSE_EN;
   endtask
   initial begin
      int prev_fc;
      bit prev_req;
      rise_t r;
      end_t e;
      prev_fc = 0; prev_req = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            prev_fc = 0; prev_req = 1'b0;
         end else begin
            if (int'(fc) != prev_fc) begin
               if (rise_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rise_unexpected actual frame_cnt=%0d required no new frame", fc);
               end else begin
                  r = rise_q.pop_front();
                  chk("rise_frame_cnt", int'(fc), r.fc);
                  chk("rise_color", int'(color), r.color);
                  chk("rise_x", int'(sx), r.x);
                  chk("rise_y", int'(sy), r.y);
                  chk("rise_missed", int'(mc), r.mc);
                  chk("rise_req", int'(phys.o_step_req), r.req);
               end
            end
            if (prev_req && !phys.o_step_req) begin
               if (end_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL end_unexpected actual req fall required none");
               end else begin
                  e = end_q.pop_front();
                  chk("end_x", int'(sx), e.x);
                  chk("end_y", int'(sy), e.y);
                  chk("end_missed", int'(mc), e.mc);
               end
            end
            prev_fc = int'(fc);
            prev_req = phys.o_step_req;
         end
      end
   end
   initial begin
      int bad;
      model_reset();
      phys.i_hit = 1'b0;
      drive_phys(1'b0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_x", int'(sx), 200);
      chk("rst_y", int'(sy), 300);
      chk("rst_color", int'(color), 'hFFF);
      chk("rst_req", int'(phys.o_step_req), 0);
      chk("rst_frame_cnt", int'(fc), 0);
      chk("rst_missed", int'(mc), 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (phys.o_step_req !== 1'b0) bad++;
         v = 10'(i);
      end
      @(negedge clk);
      chk("sweep_req_cycles", bad, 0);
      chk("sweep_x", int'(sx), 200);
      chk("sweep_y", int'(sy), 300);
      chk("sweep_color", int'(color), 'hFFF);
      chk("sweep_frame_cnt", int'(fc), 0);
      // reset in the middle of a handshake
      model_rise(1'b0, 1'b0);
      v = 10'd600;
      @(negedge clk);
      v = 10'd601;
      @(negedge clk);
      chk("mid_req_high", int'(phys.o_step_req), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_req", int'(phys.o_step_req), 0);
      chk("mid_rst_frame_cnt", int'(fc), 0);
      rst = 1'b0;
      v = 10'd0;
      model_reset();
      @(negedge clk);
      frame(5, 10, 3, 17, 42, -1, 1'b0, 1'b0);
      frame(4, 6, -1, 0, 0, -1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) frame(3, 3, -1, 0, 0, -1, 1'b0, 1'b0);
      chk("missed_saturated", int'(mc), 255);
      frame(4, 5, 5, 123, 456, -1, 1'b0, 1'b0);
      frame(6, 5, 2, 50, 60, 2, 1'b0, 1'b0);
      for (int f = 2; f <= 12; f++) frame(4, 4, 1, f, f, (f == 4) ? 1 : -1, 1'b0, 1'b0);
      frame(3, 4, 2, 7, 8, 3, 1'b0, 1'b0);
      for (int f = 0; f < 3; f++) frame(4, 4, 2, 99, 99, (f == 1) ? 0 : -1, 1'b1, 1'b0);
      frame(4, 4, 2, 11, 22, -1, 1'b0, 1'b0);
      frame(4, 5, 3, 33, 44, -1, 1'b0, 1'b1);
      for (int f = 0; f < 200; f++) begin
         int act, blank;
         act = $urandom_range(8, 1);
         blank = $urandom_range(8, 1);
         frame(act, blank, (($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(blank, 0))),
               int'($urandom_range(399, 0)), int'($urandom_range(599, 0)),
               ($urandom_range(3, 0) == 0) ? int'($urandom_range(act, 0)) : -1,
               $urandom_range(4, 0) == 0, $urandom_range(4, 0) == 0);
      end
      repeat (5) @(negedge clk);
      chk("rise_queue_drained", rise_q.size(), 0);
      chk("end_queue_drained", end_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
